// File: rtl/pixel_write_arbiter_pkg.sv
// Shared constants for the sprite pixel write arbiter: screen bounds, client IDs,
// colours and controller state encoding.
package pixel_write_arbiter_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic CLIENT_PADDLE = 1'b0;
  localparam logic CLIENT_BALL   = 1'b1;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] GREEN = 3'b010;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic logic [1:0] onehot2(input logic k);
    return k ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/pixel_write_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to rr.
module rr_pick2
  import pixel_write_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr,
  output logic       winner,
  output logic       valid
);

  always_comb begin
    valid = |req;
    if (&req) begin
      winner = rr;
    end else if (req[CLIENT_BALL]) begin
      winner = CLIENT_BALL;
    end else begin
      winner = CLIENT_PADDLE;
    end
  end

endmodule

// File: rtl/pixel_write_arbiter.sv
// Grants the framebuffer write port to the paddle or ball drawer one burst at a
// time, registers accepted pixels and masks off-screen ones.
module pixel_write_arbiter
  import pixel_write_arbiter_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int C_W      = 3,
  parameter int SCREEN_W = pixel_write_arbiter_pkg::SCREEN_W,
  parameter int SCREEN_H = pixel_write_arbiter_pkg::SCREEN_H
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [1:0]       pix_valid,
  input  logic [1:0]       pix_last,
  input  logic [2*X_W-1:0] x_in,
  input  logic [2*Y_W-1:0] y_in,
  input  logic [2*C_W-1:0] color_in,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic [X_W-1:0]   out_x,
  output logic [Y_W-1:0]   out_y,
  output logic [C_W-1:0]   out_color,
  output logic             out_plot
);

  // One extra bit so a bound equal to 2**W still compares correctly.
  localparam logic [X_W:0] X_LIM = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(SCREEN_H);

  logic [1:0] state_reg, state_next;
  logic       owner_reg, owner_next;
  logic       rr_reg, rr_next;
  logic       pick_winner, pick_valid;
  logic       accept, on_screen;

  logic [X_W-1:0] x_arr [2];
  logic [Y_W-1:0] y_arr [2];
  logic [C_W-1:0] c_arr [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
    assign x_arr[gi] = x_in[gi*X_W +: X_W];
    assign y_arr[gi] = y_in[gi*Y_W +: Y_W];
    assign c_arr[gi] = color_in[gi*C_W +: C_W];
  end

  rr_pick2 u_pick (
    .req    (req),
    .rr     (rr_reg),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  assign accept    = (state_reg == BUSY) && pix_valid[owner_reg];
  assign on_screen = ({1'b0, x_arr[owner_reg]} < X_LIM) &&
                     ({1'b0, y_arr[owner_reg]} < Y_LIM);

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    rr_next    = rr_reg;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          state_next = BUSY;
          owner_next = pick_winner;
        end
      end
      BUSY: begin
        if (accept && pix_last[owner_reg]) begin
          state_next = DONE;
        end else if (!accept && !req[owner_reg]) begin
          // Abort: release without a done pulse and let the other client go first.
          state_next = IDLE;
          rr_next    = ~owner_reg;
        end
      end
      DONE: begin
        state_next = IDLE;
        rr_next    = ~owner_reg;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      owner_reg <= CLIENT_PADDLE;
      rr_reg    <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_color <= C_W'(BLACK);
      out_plot  <= 1'b0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      rr_reg    <= rr_next;
      out_plot  <= accept && on_screen;
      if (accept) begin
        out_x     <= x_arr[owner_reg];
        out_y     <= y_arr[owner_reg];
        out_color <= c_arr[owner_reg];
      end
    end
  end

  assign gnt  = (state_reg == BUSY) ? onehot2(owner_reg) : 2'b00;
  assign done = (state_reg == DONE) ? onehot2(owner_reg) : 2'b00;

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Randomized bench for pixel_write_arbiter: bursts are checked against a
// transaction-level model of grant order, pixel forwarding and done timing.
module tb_pixel_write_arbiter;
  import pixel_write_arbiter_pkg::*;

  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req, pix_valid, pix_last;
  logic [2*X_W-1:0] x_in;
  logic [2*Y_W-1:0] y_in;
  logic [2*C_W-1:0] color_in;
  logic [1:0]       gnt, done;
  logic [X_W-1:0]   out_x;
  logic [Y_W-1:0]   out_y;
  logic [C_W-1:0]   out_color;
  logic             out_plot;

  int vectors    = 0;
  int miscompares = 0;

  // Model state: who wins the next tie, and what the output pins should hold.
  bit rr_model;
  int exp_x, exp_y, exp_c;
  int q_x[$], q_y[$], q_c[$];

  pixel_write_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .pix_valid (pix_valid),
    .pix_last  (pix_last),
    .x_in      (x_in),
    .y_in      (y_in),
    .color_in  (color_in),
    .gnt       (gnt),
    .done      (done),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_color (out_color),
    .out_plot  (out_plot)
  );

  always #5 clk = ~clk;

  function automatic bit visible(input int x, input int y);
    return (x < SCREEN_W) && (y < SCREEN_H);
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Present client k's pixel and random junk from the other client.
  task automatic drive(input int k, input int x, input int y, input int c,
                       input bit v, input bit last);
    int o;
    o = 1 - k;
    pix_valid[k] = v;
    pix_last[k]  = last;
    x_in[k*X_W +: X_W]     = X_W'(x);
    y_in[k*Y_W +: Y_W]     = Y_W'(y);
    color_in[k*C_W +: C_W] = C_W'(c);
    pix_valid[o] = 1'($urandom);
    pix_last[o]  = 1'($urandom);
    x_in[o*X_W +: X_W]     = X_W'($urandom);
    y_in[o*Y_W +: Y_W]     = Y_W'($urandom);
    color_in[o*C_W +: C_W] = C_W'($urandom);
  endtask

  // Runs one burst from IDLE using the pixels queued in q_x/q_y/q_c.
  // abort_at / reset_at: pixel index at which to abort or reset (-1 = never).
  task automatic run_burst(input logic [1:0] mask, input bit gaps,
                           input int abort_at, input int reset_at);
    int w, n, i;
    bit v;
    logic [1:0] w_hot;
    n = q_x.size();
    w = (mask == 2'b11) ? int'(rr_model) : (mask[1] ? 1 : 0);
    w_hot = 2'(1 << w);
    req = mask;
    pix_valid = 2'b00;
    tick();
    vectors++;
    if (gnt !== w_hot) begin
      miscompares++;
      $display("FAIL grant_start: gnt=%b expected %b", gnt, w_hot);
    end
    i = 0;
    while (i < n) begin
      if (i == abort_at) begin
        req[w] = 1'b0;
        drive(w, 0, 0, 0, 1'b0, 1'b0);
        tick();
        vectors++;
        if (gnt !== 2'b00 || done !== 2'b00 || out_plot !== 1'b0) begin
          miscompares++;
          $display("FAIL abort: gnt=%b done=%b plot=%b expected 00 00 0", gnt, done, out_plot);
        end
        rr_model = ~w[0];
        req = mask & ~w_hot;
        return;
      end
      if (i == reset_at) begin
        drive(w, q_x[i], q_y[i], q_c[i], 1'b1, 1'b0);
        reset = 1'b1;
        tick();
        vectors++;
        if (gnt !== 2'b00 || done !== 2'b00 || out_plot !== 1'b0 ||
            out_x !== '0 || out_y !== '0 || out_color !== '0) begin
          miscompares++;
          $display("FAIL mid_reset: gnt=%b done=%b plot=%b x=%0d y=%0d c=%0d expected all 0",
                   gnt, done, out_plot, out_x, out_y, out_color);
        end
        reset = 1'b0;
        req = 2'b00;
        pix_valid = 2'b00;
        rr_model = 1'b0;
        exp_x = 0; exp_y = 0; exp_c = 0;
        return;
      end
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      drive(w, q_x[i], q_y[i], q_c[i], v, v ? (i == n - 1) : 1'($urandom));
      tick();
      vectors++;
      if (v) begin
        exp_x = q_x[i]; exp_y = q_y[i]; exp_c = q_c[i];
        if (out_plot !== visible(q_x[i], q_y[i]) || out_x !== X_W'(exp_x) ||
            out_y !== Y_W'(exp_y) || out_color !== C_W'(exp_c)) begin
          miscompares++;
          $display("FAIL pixel%0d: plot=%b x=%0d y=%0d c=%0d expected %b %0d %0d %0d", i,
                   out_plot, out_x, out_y, out_color, visible(q_x[i], q_y[i]), exp_x, exp_y, exp_c);
        end
        vectors++;
        if (i == n - 1) begin
          if (done !== w_hot || gnt !== 2'b00) begin
            miscompares++;
            $display("FAIL done_pulse: done=%b gnt=%b expected %b 00", done, gnt, w_hot);
          end
        end else if (done !== 2'b00 || gnt !== w_hot) begin
          miscompares++;
          $display("FAIL busy_hold: done=%b gnt=%b expected 00 %b", done, gnt, w_hot);
        end
        i++;
      end else begin
        if (out_plot !== 1'b0 || out_x !== X_W'(exp_x) || out_y !== Y_W'(exp_y) ||
            out_color !== C_W'(exp_c) || gnt !== w_hot || done !== 2'b00) begin
          miscompares++;
          $display("FAIL idle_cycle: plot=%b x=%0d gnt=%b done=%b expected 0 %0d %b 00",
                   out_plot, out_x, gnt, done, exp_x, w_hot);
        end
      end
    end
    req[w] = 1'b0;
    pix_valid = 2'b00;
    tick();
    vectors++;
    if (done !== 2'b00 || gnt !== 2'b00) begin
      miscompares++;
      $display("FAIL after_done: done=%b gnt=%b expected 00 00", done, gnt);
    end
    rr_model = ~w[0];
    $display("burst client=%0d pixels=%0d done", w, n);
  endtask

  task automatic load_random(input int n);
    q_x.delete(); q_y.delete(); q_c.delete();
    for (int i = 0; i < n; i++) begin
      q_x.push_back($urandom_range(0, 255));
      q_y.push_back($urandom_range(0, 127));
      q_c.push_back($urandom_range(0, 7));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      req = 2'($urandom); pix_valid = 2'($urandom); pix_last = 2'($urandom);
      x_in = 16'($urandom); y_in = 14'($urandom); color_in = 6'($urandom);
      tick();
      vectors++;
      if (gnt !== 2'b00 || done !== 2'b00 || out_plot !== 1'b0 ||
          out_x !== '0 || out_y !== '0 || out_color !== '0) begin
        miscompares++;
        $display("FAIL reset_state: gnt=%b done=%b plot=%b x=%0d y=%0d c=%0d expected all 0",
                 gnt, done, out_plot, out_x, out_y, out_color);
      end
    end
    reset = 1'b0; req = 2'b00; pix_valid = 2'b00;
    rr_model = 1'b0;
    exp_x = 0; exp_y = 0; exp_c = 0;
    tick();
    vectors++;
    if (gnt !== 2'b00 || out_plot !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle: gnt=%b plot=%b expected 00 0", gnt, out_plot);
    end
    $display("reset checked");
  endtask

  task automatic test_single_paddle();
    q_x.delete(); q_y.delete(); q_c.delete();
    for (int i = 0; i < 16; i++) begin
      q_x.push_back(75 + i); q_y.push_back(108); q_c.push_back(int'(GREEN));
    end
    run_burst(2'b01, 1'b0, -1, -1);
  endtask

  task automatic test_both_requests();
    for (int b = 0; b < 4; b++) begin
      load_random($urandom_range(1, 6));
      run_burst(2'b11, 1'b1, -1, -1);
    end
  endtask

  task automatic test_offscreen();
    q_x = '{170, 10, 10};
    q_y = '{50, 119, 120};
    q_c = '{1, 2, 3};
    run_burst(2'b10, 1'b0, -1, -1);
  endtask

  task automatic test_abort();
    load_random(10);
    run_burst(2'b11, 1'b0, 5, -1);
    load_random(4);
    run_burst(req, 1'b0, -1, -1);
  endtask

  task automatic test_reset_mid_burst();
    load_random(12);
    run_burst(2'b11, 1'b0, -1, 8);
    tick();
    load_random(3);
    run_burst(2'b11, 1'b0, -1, -1);
  endtask

  task automatic test_random();
    logic [1:0] m;
    for (int b = 0; b < 25; b++) begin
      m = 2'($urandom_range(1, 3));
      load_random($urandom_range(1, 10));
      run_burst(m, 1'b1, ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1, -1);
      req = 2'b00;
      if ($urandom_range(0, 1) == 1) tick();
    end
  endtask

  initial begin
    reset = 1'b1; req = 2'b00; pix_valid = 2'b00; pix_last = 2'b00;
    x_in = '0; y_in = '0; color_in = '0;
    test_reset();
    test_single_paddle();
    test_both_requests();
    req = 2'b00;
    tick();
    test_offscreen();
    test_abort();
    req = 2'b00;
    tick();
    test_reset_mid_burst();
    req = 2'b00;
    tick();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
